// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiters: FSM encoding, timing defaults
// and the helper that locates one slave's field inside a flattened bus.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  localparam int RELEASE_GAP_DEF = 3;
  localparam int TIMEOUT_CYC_DEF = 4096;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter_core.sv
// Round-robin priority picker: the first requester after the stored pointer
// wins; the pointer moves to the winner when update is strobed.
module rr_arbiter_core #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!grant_any && req[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  // Pointer starts at the last slot so slave 0 has top priority after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= IDX_W'(NUM_REQ - 1);
    else if (update && grant_any)
      ptr <= grant_idx;
  end

endmodule

// File: rtl/ddr_wr_port_arbiter.sv
// Shares one DDR write command/data port among several slave FIFOs with
// round-robin grants, a release gap between owners and a stall timeout.
module ddr_wr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_W      = 25,
  parameter int LEN_W       = 10,
  parameter int DATA_W      = 16,
  parameter int RELEASE_GAP = RELEASE_GAP_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                         ddr_clk,
  input  logic                         sys_rst,
  input  logic [NUM_SLAVES-1:0]        slave_req,
  input  logic [NUM_SLAVES*ADDR_W-1:0] slave_waddr,
  input  logic [NUM_SLAVES*LEN_W-1:0]  slave_wburst_len,
  output logic [NUM_SLAVES-1:0]        arbitrate_valid,
  output logic [NUM_SLAVES-1:0]        slave_fifo_rden,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_fifo_dout,
  output logic                         ddr_wr_req,
  input  logic                         ddr_wr_ack,
  output logic [ADDR_W-1:0]            ddr_wr_addr,
  output logic [LEN_W-1:0]             ddr_wr_len,
  input  logic                         ddr_wdata_req,
  output logic [DATA_W-1:0]            ddr_wdata,
  input  logic                         ddr_wr_done,
  output logic                         err_timeout,
  output logic                         err_len
);

  localparam int IDX_W = $clog2(NUM_SLAVES);
  localparam int GAP_W = $clog2(RELEASE_GAP + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [ADDR_W-1:0] addr_arr [NUM_SLAVES];
  logic [LEN_W-1:0]  len_arr  [NUM_SLAVES];
  logic [DATA_W-1:0] dout_arr [NUM_SLAVES];

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_unpack
    assign addr_arr[i] = slave_waddr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign len_arr[i]  = slave_wburst_len[slice_lo(i, LEN_W) +: LEN_W];
    assign dout_arr[i] = slave_fifo_dout[slice_lo(i, DATA_W) +: DATA_W];
  end

  arb_state_t            state;
  logic [IDX_W-1:0]      gidx;
  logic [LEN_W:0]        beat_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [NUM_SLAVES-1:0] rr_grant;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_any;
  logic                  beat;
  logic                  tmo_hit;
  logic [LEN_W:0]        beats_now;

  rr_arbiter_core #(.NUM_REQ(NUM_SLAVES)) u_rr (
    .clk       (ddr_clk),
    .rst       (sys_rst),
    .req       (slave_req),
    .update    (state == ST_IDLE),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .grant_any (rr_any)
  );

  // Beat counter is one bit wider than the length so a full-length burst cannot wrap
  assign beat      = (state == ST_DATA) && ddr_wdata_req && (beat_cnt < {1'b0, ddr_wr_len});
  assign beats_now = beat_cnt + {{LEN_W{1'b0}}, beat};
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    slave_fifo_rden       = '0;
    slave_fifo_rden[gidx] = beat;
    ddr_wdata             = (state == ST_DATA) ? dout_arr[gidx] : '0;
  end

  always_ff @(posedge ddr_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state           <= ST_IDLE;
      gidx            <= '0;
      arbitrate_valid <= '0;
      ddr_wr_req      <= 1'b0;
      ddr_wr_addr     <= '0;
      ddr_wr_len      <= '0;
      beat_cnt        <= '0;
      tmo_cnt         <= '0;
      gap_cnt         <= '0;
      err_timeout     <= 1'b0;
      err_len         <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      err_len     <= 1'b0;
      if (beat)
        beat_cnt <= beat_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (rr_any) begin
            gidx            <= rr_idx;
            arbitrate_valid <= rr_grant;
            ddr_wr_addr     <= addr_arr[rr_idx];
            ddr_wr_len      <= len_arr[rr_idx];
            beat_cnt        <= '0;
            tmo_cnt         <= '0;
            gap_cnt         <= '0;
            if (len_arr[rr_idx] == '0) begin
              state <= ST_RELEASE;
            end else begin
              state      <= ST_CMD;
              ddr_wr_req <= 1'b1;
            end
          end
        end
        ST_CMD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (tmo_hit) begin
            err_timeout     <= 1'b1;
            ddr_wr_req      <= 1'b0;
            arbitrate_valid <= '0;
            gap_cnt         <= '0;
            state           <= ST_RELEASE;
          end else if (ddr_wr_ack) begin
            ddr_wr_req <= 1'b0;
            state      <= ST_DATA;
          end
        end
        // A completing burst takes precedence over a timeout in the same cycle
        ST_DATA: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (ddr_wr_done) begin
            err_len         <= (beats_now != {1'b0, ddr_wr_len});
            arbitrate_valid <= '0;
            gap_cnt         <= '0;
            state           <= ST_RELEASE;
          end else if (tmo_hit) begin
            err_timeout     <= 1'b1;
            arbitrate_valid <= '0;
            gap_cnt         <= '0;
            state           <= ST_RELEASE;
          end
        end
        // Gap counting starts only once valid is low, so slaves see the full gap
        ST_RELEASE: begin
          if (|arbitrate_valid)
            arbitrate_valid <= '0;
          else if (gap_cnt == GAP_W'(RELEASE_GAP - 1))
            state <= ST_IDLE;
          else
            gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_port_arbiter.sv
// Directed bench for ddr_wr_port_arbiter: grant order, burst steering,
// length/timeout errors, zero-length bursts and asynchronous reset.
module tb_ddr_wr_port_arbiter;

  localparam int NS = 4;
  localparam int AW = 25;
  localparam int LW = 10;
  localparam int DW = 16;

  logic              ddr_clk = 1'b0;
  logic              sys_rst;
  logic [NS-1:0]     slave_req;
  logic [AW-1:0]     waddr_a [NS];
  logic [LW-1:0]     len_a   [NS];
  logic [DW-1:0]     dout_a  [NS];
  logic [NS*AW-1:0]  slave_waddr;
  logic [NS*LW-1:0]  slave_wburst_len;
  logic [NS*DW-1:0]  slave_fifo_dout;
  logic [NS-1:0]     arbitrate_valid;
  logic [NS-1:0]     slave_fifo_rden;
  logic              ddr_wr_req;
  logic              ddr_wr_ack;
  logic [AW-1:0]     ddr_wr_addr;
  logic [LW-1:0]     ddr_wr_len;
  logic              ddr_wdata_req;
  logic [DW-1:0]     ddr_wdata;
  logic              ddr_wr_done;
  logic              err_timeout;
  logic              err_len;

  int n_tests = 0;
  int n_fail  = 0;

  assign slave_waddr      = {waddr_a[3], waddr_a[2], waddr_a[1], waddr_a[0]};
  assign slave_wburst_len = {len_a[3], len_a[2], len_a[1], len_a[0]};
  assign slave_fifo_dout  = {dout_a[3], dout_a[2], dout_a[1], dout_a[0]};

  always #5 ddr_clk = ~ddr_clk;

  ddr_wr_port_arbiter dut (
    .ddr_clk          (ddr_clk),
    .sys_rst          (sys_rst),
    .slave_req        (slave_req),
    .slave_waddr      (slave_waddr),
    .slave_wburst_len (slave_wburst_len),
    .arbitrate_valid  (arbitrate_valid),
    .slave_fifo_rden  (slave_fifo_rden),
    .slave_fifo_dout  (slave_fifo_dout),
    .ddr_wr_req       (ddr_wr_req),
    .ddr_wr_ack       (ddr_wr_ack),
    .ddr_wr_addr      (ddr_wr_addr),
    .ddr_wr_len       (ddr_wr_len),
    .ddr_wdata_req    (ddr_wdata_req),
    .ddr_wdata        (ddr_wdata),
    .ddr_wr_done      (ddr_wr_done),
    .err_timeout      (err_timeout),
    .err_len          (err_len)
  );

  task automatic set_slave(input logic [1:0] i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    waddr_a[i] = a;
    len_a[i]   = l;
  endtask

  task automatic drain();
    repeat (8) @(negedge ddr_clk);
  endtask

  task automatic test_reset();
    sys_rst       = 1'b1;
    slave_req     = '0;
    ddr_wr_ack    = 1'b0;
    ddr_wdata_req = 1'b0;
    ddr_wr_done   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      waddr_a[i] = '0;
      len_a[i]   = '0;
      dout_a[i]  = '0;
    end
    repeat (2) @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid got %b exp 0000", arbitrate_valid); end
    n_tests++;
    if (ddr_wr_req !== 1'b0) begin n_fail++; $display("FAIL reset_wr_req got %b exp 0", ddr_wr_req); end
    n_tests++;
    if (slave_fifo_rden !== 4'b0000) begin n_fail++; $display("FAIL reset_rden got %b exp 0000", slave_fifo_rden); end
    n_tests++;
    if ({ddr_wr_addr, ddr_wr_len, ddr_wdata} !== '0) begin n_fail++; $display("FAIL reset_addr_len_data got %h/%h/%h exp 0", ddr_wr_addr, ddr_wr_len, ddr_wdata); end
    n_tests++;
    if ({err_timeout, err_len} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b exp 00", {err_timeout, err_len}); end
    @(negedge ddr_clk);
    sys_rst = 1'b0;
  endtask

  task automatic test_round_robin();
    int exp_seq [5];
    int low;
    bit seen;
    bit req_seen;
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NS; i++) set_slave(2'(i), 25'h0100000 + 25'(i * 16), 10'd0);
    slave_req = 4'b1111;
    req_seen  = 1'b0;
    for (int n = 0; n < 5; n++) begin
      low  = 0;
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge ddr_clk);
        #1;
        if (ddr_wr_req) req_seen = 1'b1;
        if (arbitrate_valid != '0) seen = 1'b1;
        else low++;
      end
      n_tests++;
      if (arbitrate_valid !== (4'b0001 << exp_seq[n])) begin
        n_fail++; $display("FAIL rr_grant%0d got %b exp %b", n, arbitrate_valid, 4'b0001 << exp_seq[n]);
      end
      n_tests++;
      if (ddr_wr_addr !== 25'h0100000 + 25'(exp_seq[n] * 16)) begin
        n_fail++; $display("FAIL rr_addr%0d got %h exp %h", n, ddr_wr_addr, 25'h0100000 + 25'(exp_seq[n] * 16));
      end
      if (n > 0) begin
        n_tests++;
        if (low !== 4) begin n_fail++; $display("FAIL rr_gap%0d got %0d exp 4", n, low); end
      end
      if (n == 4) slave_req = '0;
    end
    n_tests++;
    if (req_seen !== 1'b0) begin n_fail++; $display("FAIL rr_zero_len_wr_req got %b exp 0", req_seen); end
    drain();
  endtask

  task automatic test_single_burst();
    int rd;
    int bad;
    int early;
    set_slave(2'd2, 25'h0001000, 10'd256);
    set_slave(2'd3, 25'h0003000, 10'd0);
    slave_req = 4'b0100;
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b exp 0100", arbitrate_valid); end
    n_tests++;
    if (ddr_wr_req !== 1'b1) begin n_fail++; $display("FAIL single_wr_req got %b exp 1", ddr_wr_req); end
    n_tests++;
    if (ddr_wr_addr !== 25'h0001000 || ddr_wr_len !== 10'd256) begin
      n_fail++; $display("FAIL single_cmd got %h/%0d exp 0001000/256", ddr_wr_addr, ddr_wr_len);
    end
    slave_req  = '0;
    ddr_wr_ack = 1'b1;
    @(negedge ddr_clk);
    ddr_wr_ack = 1'b0;
    #1;
    n_tests++;
    if (ddr_wr_req !== 1'b0) begin n_fail++; $display("FAIL single_req_after_ack got %b exp 0", ddr_wr_req); end
    rd  = 0;
    bad = 0;
    for (int b = 0; b < 260; b++) begin
      ddr_wdata_req = 1'b1;
      dout_a[2]     = 16'hC000 + 16'(b);
      dout_a[0]     = 16'hDEAD;
      #1;
      if (slave_fifo_rden[2]) begin
        rd++;
        if (ddr_wdata !== 16'hC000 + 16'(b)) bad++;
      end
      if ((slave_fifo_rden & 4'b1011) != '0) bad++;
      @(negedge ddr_clk);
    end
    ddr_wdata_req = 1'b0;
    n_tests++;
    if (rd !== 256) begin n_fail++; $display("FAIL single_rden_count got %0d exp 256", rd); end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL single_wdata_steer got %0d bad beats exp 0", bad); end
    ddr_wr_done = 1'b1;
    slave_req   = 4'b1000;
    @(negedge ddr_clk);
    ddr_wr_done = 1'b0;
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0000) begin n_fail++; $display("FAIL single_valid_fall got %b exp 0000", arbitrate_valid); end
    n_tests++;
    if (err_len !== 1'b0) begin n_fail++; $display("FAIL single_err_len got %b exp 0", err_len); end
    early = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge ddr_clk);
      #1;
      if (arbitrate_valid != '0) early++;
    end
    n_tests++;
    if (early !== 0) begin n_fail++; $display("FAIL single_release_gap got %0d early grants exp 0", early); end
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b1000) begin n_fail++; $display("FAIL single_next_grant got %b exp 1000", arbitrate_valid); end
    slave_req = '0;
    drain();
  endtask

  task automatic test_len_mismatch();
    int rd;
    int pulses;
    set_slave(2'd0, 25'h00ABCDE, 10'd256);
    slave_req = 4'b0001;
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0001) begin n_fail++; $display("FAIL short_grant got %b exp 0001", arbitrate_valid); end
    slave_req  = '0;
    ddr_wr_ack = 1'b1;
    @(negedge ddr_clk);
    ddr_wr_ack = 1'b0;
    rd = 0;
    for (int b = 0; b < 200; b++) begin
      ddr_wdata_req = 1'b1;
      #1;
      if (slave_fifo_rden[0]) rd++;
      @(negedge ddr_clk);
    end
    ddr_wdata_req = 1'b0;
    ddr_wr_done   = 1'b1;
    @(negedge ddr_clk);
    ddr_wr_done = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (err_len) pulses++;
      @(negedge ddr_clk);
    end
    n_tests++;
    if (rd !== 200) begin n_fail++; $display("FAIL short_rden_count got %0d exp 200", rd); end
    n_tests++;
    if (pulses !== 1) begin n_fail++; $display("FAIL short_err_len_pulses got %0d exp 1", pulses); end
    drain();
  endtask

  task automatic test_len_zero();
    int  vcnt;
    bit  req_seen;
    bit  rden_seen;
    set_slave(2'd1, 25'h0000111, 10'd0);
    slave_req     = 4'b0010;
    ddr_wdata_req = 1'b1;
    vcnt      = 0;
    req_seen  = 1'b0;
    rden_seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge ddr_clk);
      #1;
      if (arbitrate_valid == 4'b0010) begin vcnt++; slave_req = '0; end
      if (ddr_wr_req) req_seen = 1'b1;
      if (slave_fifo_rden != '0) rden_seen = 1'b1;
    end
    ddr_wdata_req = 1'b0;
    n_tests++;
    if (vcnt !== 1) begin n_fail++; $display("FAIL zero_valid_cycles got %0d exp 1", vcnt); end
    n_tests++;
    if (req_seen !== 1'b0) begin n_fail++; $display("FAIL zero_wr_req got %b exp 0", req_seen); end
    n_tests++;
    if (rden_seen !== 1'b0) begin n_fail++; $display("FAIL zero_rden got %b exp 0", rden_seen); end
    drain();
  endtask

  task automatic test_timeout();
    bit seen;
    set_slave(2'd2, 25'h0002000, 10'd16);
    set_slave(2'd3, 25'h0003000, 10'd0);
    slave_req = 4'b1100;
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0100) begin n_fail++; $display("FAIL tmo_grant got %b exp 0100", arbitrate_valid); end
    slave_req = 4'b1000;
    repeat (4095) @(negedge ddr_clk);
    #1;
    n_tests++;
    if (ddr_wr_req !== 1'b1 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_before got req=%b err=%b exp req=1 err=0", ddr_wr_req, err_timeout);
    end
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse got %b exp 1", err_timeout); end
    n_tests++;
    if (ddr_wr_req !== 1'b0 || arbitrate_valid !== 4'b0000) begin
      n_fail++; $display("FAIL tmo_abort got req=%b valid=%b exp 0/0000", ddr_wr_req, arbitrate_valid);
    end
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width got %b exp 0", err_timeout); end
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge ddr_clk);
      #1;
      if (arbitrate_valid != '0) seen = 1'b1;
    end
    n_tests++;
    if (arbitrate_valid !== 4'b1000) begin n_fail++; $display("FAIL tmo_next_grant got %b exp 1000", arbitrate_valid); end
    slave_req = '0;
    drain();
  endtask

  task automatic test_reset_mid();
    set_slave(2'd2, 25'h1F00000, 10'd64);
    dout_a[2] = 16'hBEEF;
    slave_req = 4'b0100;
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant got %b exp 0100", arbitrate_valid); end
    slave_req  = '0;
    ddr_wr_ack = 1'b1;
    @(negedge ddr_clk);
    ddr_wr_ack    = 1'b0;
    ddr_wdata_req = 1'b1;
    repeat (10) @(negedge ddr_clk);
    #1;
    n_tests++;
    if (slave_fifo_rden !== 4'b0100 || ddr_wdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rstmid_data got rden=%b data=%h exp 0100/beef", slave_fifo_rden, ddr_wdata);
    end
    #1;
    sys_rst = 1'b1;
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0000 || slave_fifo_rden !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_valid_rden got %b/%b exp 0000/0000", arbitrate_valid, slave_fifo_rden);
    end
    n_tests++;
    if ({ddr_wr_req, err_timeout, err_len} !== 3'b000 || ddr_wdata !== 16'h0000) begin
      n_fail++; $display("FAIL rstmid_ctrl got req/errs=%b data=%h exp 000/0000", {ddr_wr_req, err_timeout, err_len}, ddr_wdata);
    end
    n_tests++;
    if (ddr_wr_addr !== 25'h0 || ddr_wr_len !== 10'h0) begin
      n_fail++; $display("FAIL rstmid_addr_len got %h/%h exp 0/0", ddr_wr_addr, ddr_wr_len);
    end
    ddr_wdata_req = 1'b0;
    @(negedge ddr_clk);
    sys_rst = 1'b0;
    set_slave(2'd1, 25'h0000010, 10'd0);
    set_slave(2'd3, 25'h0000030, 10'd0);
    slave_req = 4'b1010;
    @(negedge ddr_clk);
    #1;
    n_tests++;
    if (arbitrate_valid !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first_grant got %b exp 0010", arbitrate_valid); end
    slave_req = '0;
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_burst();
    test_len_mismatch();
    test_len_zero();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
